control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter MD_MAX_CYCLES, default 40: upper bound on SALU cycles spent waiting for multiply/divide completion.
REQ-002 SHALL have port ck  in  1  clock; all state changes on rising edge.
REQ-003 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-004 SHALL have port ir  in  32  current instruction word, held stable by datapath from end of SFETCH until next SFETCH.
REQ-005 SHALL have port end_mul  in  1  multiplier done pulse.
REQ-006 SHALL have port end_div  in  1  divider done pulse.
REQ-007 SHALL have port inst  out  inst_type  decoded instruction.
REQ-008 SHALL have port uins  out  microinstruction  per-cycle datapath control.
REQ-009 SHALL have port md_timeout  out  1  sticky flag: multiply/divide wait exceeded MD_MAX_CYCLES.

Function
REQ-010 SHALL decode ir combinationally; ir==0 -> NOP.
REQ-011 SHALL decode opcode ir[31:26]=00h by funct ir[5:0]: SSLL 00, SSRL 02, SSRA 03, SLLV 04, SRLV 06, SRAV 07, JR 08, JALR 09, MFHI 10, MFLO 12, MULTU 19, DIVU 1B, ADDU 21, SUBU 23, AAND 24, OOR 25, XXOR 26, NNOR 27, SLT 2A, SLTU 2B.
REQ-012 SHALL decode other opcodes (hex): J 02, JAL 03, BEQ 04, BNE 05, BLEZ 06, ADDI 08/09, SLTI 0A, SLTIU 0B, ANDI 0C, ORI 0D, XORI 0E, LUI 0F, LW 23, LBU 24, SB 28, SW 2B, BGEZ 01 with ir[20:16]=01h.
REQ-013 SHALL decode any other encoding as invalid_instruction.
REQ-014 SHALL implement FSM states SIDLE, SFETCH, SREG, SALU, WBK, SLD, SST, SSALTA.
REQ-015 SHALL use transitions SIDLE->SFETCH; SFETCH->SREG; SREG->SFETCH if NOP or invalid_instruction, else SALU.
REQ-016 SHALL leave SALU to: SLD for LW/LBU; SST for SW/SB; SSALTA for BEQ/BNE/BLEZ/BGEZ/J/JR; WBK for all other types except MULTU/DIVU.
REQ-017 SHALL transition SLD->WBK, and WBK/SST/SSALTA->SFETCH.
REQ-018 SHALL, for MULTU/DIVU, hold SALU until end_mul (MULTU) or end_div (DIVU) is sampled high, then go to SFETCH; the wrong done flag SHALL be ignored.
REQ-019 SHALL count SALU cycles for MULTU/DIVU; at count == MD_MAX_CYCLES without done, SHALL go to SFETCH and set md_timeout, which stays 1 until rst.
REQ-020 SHALL generate uins as a Moore-style function of state and inst; every field not listed below is 0.
REQ-021 SHALL drive in SFETCH: CY1=1, ce=1, rw=1. In SREG: CY2=1.
REQ-022 SHALL drive walu=1 in SALU; i=1 in SALU when inst in {ADDI, ANDI, ORI, XORI, SLTI, SLTIU, LUI, LW, LBU, SW, SB}.
REQ-023 SHALL drive rst_md=1 only in the first SALU cycle of MULTU/DIVU.
REQ-024 SHALL drive whilo=1 and wpc=1 in the SALU cycle where the matching done flag is sampled high; on timeout, only wpc=1.
REQ-025 SHALL drive in SLD: wmdr=1, ce=1, rw=1. In WBK: wreg=1, wpc=1.
REQ-026 SHALL drive in SST: ce=1, rw=0, wpc=1, and bw=1 for SW, bw=0 for SB.
REQ-027 SHALL drive wpc=1 in SSALTA; the datapath resolves the branch condition.
REQ-028 SHALL drive all uins fields to 0 in SIDLE.

Reset
REQ-029 SHALL, on rst high at a clock edge, go to SIDLE, clear the MD counter and md_timeout, and output all-zero uins on the next cycle, regardless of current state, including mid-SALU wait.
REQ-030 SHALL have rst take priority over end_mul/end_div sampled in the same cycle.

Structure
REQ-031 SHALL take inst_type and microinstruction from package riscv; the FSM state enum SHALL be added to that package.
REQ-032 SHALL place decode in one combinational sub-module, inst_decoder (in ir, out inst); FSM and counter stay in control_unit.

Verification
REQ-033 Reset mid-SALU for MULTU, then release: next cycle SIDLE with uins all 0, then SFETCH with CY1=ce=rw=1.
REQ-034 ir=8C430004 (LW): SFETCH, SREG, SALU(i=1), SLD(wmdr=1), WBK(wreg=wpc=1); 5 cycles; next SFETCH.
REQ-035 ir=AC430004 (SW) -> SST with bw=1, rw=0; ir=A0430004 (SB) -> SST with bw=0.
REQ-036 ir=00430019 (MULTU), end_mul on 5th SALU cycle with end_div pulses before: rst_md only in SALU cycle 1, whilo=wpc=1 in SALU cycle 5, next state SFETCH.
REQ-037 DIVU with MD_MAX_CYCLES=8 and no end_div: leaves SALU after 8 cycles, whilo never 1, md_timeout=1 until rst.
REQ-038 ir=FC000000 -> inst=invalid_instruction, SFETCH->SREG->SFETCH, no walu/wreg/wpc asserted; ir=0 -> inst=NOP, same path.

Source files
------------

// File: rtl/riscv.sv
// Package riscv: shared types for the MIPS-subset control path.
//   inst_type        -- decoded instruction class (6-bit enum)
//   microinstruction -- per-cycle datapath control word
//   state_t          -- control FSM state encoding
//   uses_imm / is_md -- classification helpers used by the FSM
package riscv;

    typedef enum logic [5:0] {
        NOP, invalid_instruction,
        SSLL, SSRL, SSRA, SLLV, SRLV, SRAV, JR, JALR, MFHI, MFLO,
        MULTU, DIVU, ADDU, SUBU, AAND, OOR, XXOR, NNOR, SLT, SLTU,
        J, JAL, BEQ, BNE, BLEZ, BGEZ,
        ADDI, SLTI, SLTIU, ANDI, ORI, XORI, LUI,
        LW, LBU, SB, SW
    } inst_type;

    typedef struct packed {
        logic CY1;
        logic CY2;
        logic walu;
        logic i;
        logic rst_md;
        logic whilo;
        logic wpc;
        logic wmdr;
        logic ce;
        logic rw;
        logic wreg;
        logic bw;
    } microinstruction;

    // Encodings are fixed so waveform/debug tooling can rely on them.
    typedef enum logic [2:0] {
        SIDLE  = 3'd0,
        SFETCH = 3'd1,
        SREG   = 3'd2,
        SALU   = 3'd3,
        WBK    = 3'd4,
        SLD    = 3'd5,
        SST    = 3'd6,
        SSALTA = 3'd7
    } state_t;

    // Instructions whose ALU second operand is the immediate field.
    function automatic logic uses_imm(input inst_type t);
        return t inside {ADDI, ANDI, ORI, XORI, SLTI, SLTIU, LUI, LW, LBU, SW, SB};
    endfunction

    // Multi-cycle multiply/divide instructions.
    function automatic logic is_md(input inst_type t);
        return t inside {MULTU, DIVU};
    endfunction

endpackage

// File: rtl/inst_decoder.sv
// inst_decoder: purely combinational instruction decode.
//   ir   (in, 32)         instruction word
//   inst (out, inst_type) decoded class; invalid_instruction if unrecognised
module inst_decoder
    import riscv::*;
(
    input  logic [31:0] ir,
    output inst_type    inst
);

    always_comb begin
        inst = invalid_instruction;
        if (ir == 32'h0) begin
            // All-zero word is the canonical NOP, even though it aliases SLL.
            inst = NOP;
        end else begin
            case (ir[31:26])
                6'h00: begin
                    case (ir[5:0])
                        6'h00:   inst = SSLL;
                        6'h02:   inst = SSRL;
                        6'h03:   inst = SSRA;
                        6'h04:   inst = SLLV;
                        6'h06:   inst = SRLV;
                        6'h07:   inst = SRAV;
                        6'h08:   inst = JR;
                        6'h09:   inst = JALR;
                        6'h10:   inst = MFHI;
                        6'h12:   inst = MFLO;
                        6'h19:   inst = MULTU;
                        6'h1B:   inst = DIVU;
                        6'h21:   inst = ADDU;
                        6'h23:   inst = SUBU;
                        6'h24:   inst = AAND;
                        6'h25:   inst = OOR;
                        6'h26:   inst = XXOR;
                        6'h27:   inst = NNOR;
                        6'h2A:   inst = SLT;
                        6'h2B:   inst = SLTU;
                        default: inst = invalid_instruction;
                    endcase
                end
                // REGIMM group: only BGEZ (rt = 1) is supported.
                6'h01:   inst = (ir[20:16] == 5'h01) ? BGEZ : invalid_instruction;
                6'h02:   inst = J;
                6'h03:   inst = JAL;
                6'h04:   inst = BEQ;
                6'h05:   inst = BNE;
                6'h06:   inst = BLEZ;
                6'h08:   inst = ADDI;
                6'h09:   inst = ADDI;   // ADDIU shares the ADDI datapath
                6'h0A:   inst = SLTI;
                6'h0B:   inst = SLTIU;
                6'h0C:   inst = ANDI;
                6'h0D:   inst = ORI;
                6'h0E:   inst = XORI;
                6'h0F:   inst = LUI;
                6'h23:   inst = LW;
                6'h24:   inst = LBU;
                6'h28:   inst = SB;
                6'h2B:   inst = SW;
                default: inst = invalid_instruction;
            endcase
        end
    end

endmodule

// File: rtl/control_unit.sv
// control_unit: multi-cycle control FSM for the MIPS-subset datapath.
//   ck, rst          clock / synchronous active-high reset
//   ir (32)          instruction word, stable from end of SFETCH to next SFETCH
//   end_mul, end_div multiplier / divider done pulses
//   inst             decoded instruction
//   uins             per-cycle datapath control word
//   md_timeout       sticky: a MULTU/DIVU wait hit MD_MAX_CYCLES
//   dbg_state        current FSM state, for observation only
module control_unit
    import riscv::*;
#(
    parameter int MD_MAX_CYCLES = 40
) (
    input  logic            ck,
    input  logic            rst,
    input  logic [31:0]     ir,
    input  logic            end_mul,
    input  logic            end_div,
    output inst_type        inst,
    output microinstruction uins,
    output logic            md_timeout,
    output state_t          dbg_state
);

    localparam int CW = $clog2(MD_MAX_CYCLES + 1);

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_md_cnt;     // SALU cycles already completed in this MD wait
    logic [CW-1:0]   w_md_cycle;   // 1-based index of the current SALU cycle
    logic            r_md_timeout;
    logic            w_md_wait;
    logic            w_md_done;
    logic            w_md_expire;
    microinstruction w_uins;

    inst_decoder u_dec (
        .ir   (ir),
        .inst (inst)
    );

    assign w_md_wait   = (r_state == SALU) && is_md(inst);
    assign w_md_cycle  = r_md_cnt + CW'(1);
    // Only the done flag matching the instruction counts.
    assign w_md_done   = (inst == MULTU && end_mul) || (inst == DIVU && end_div);
    // Done wins over expiry when both land in the last allowed cycle.
    assign w_md_expire = !w_md_done && (w_md_cycle == CW'(MD_MAX_CYCLES));

    always_ff @(posedge ck) begin
        if (rst) begin
            r_state      <= SIDLE;
            r_md_cnt     <= '0;
            r_md_timeout <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_md_wait && !w_md_done && !w_md_expire) begin
                r_md_cnt <= w_md_cycle;
            end else begin
                r_md_cnt <= '0;
            end
            if (w_md_wait && w_md_expire) begin
                r_md_timeout <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            SIDLE:  w_next = SFETCH;
            SFETCH: w_next = SREG;
            SREG:   w_next = (inst == NOP || inst == invalid_instruction) ? SFETCH : SALU;
            SALU: begin
                if (inst inside {LW, LBU})                        w_next = SLD;
                else if (inst inside {SW, SB})                    w_next = SST;
                else if (inst inside {BEQ, BNE, BLEZ, BGEZ, J, JR}) w_next = SSALTA;
                else if (is_md(inst))                             w_next = (w_md_done || w_md_expire) ? SFETCH : SALU;
                else                                              w_next = WBK;
            end
            SLD:    w_next = WBK;
            WBK:    w_next = SFETCH;
            SST:    w_next = SFETCH;
            SSALTA: w_next = SFETCH;
            default: w_next = SIDLE;
        endcase
    end

    always_comb begin
        w_uins = '0;
        case (r_state)
            SFETCH: begin
                w_uins.CY1 = 1'b1;
                w_uins.ce  = 1'b1;
                w_uins.rw  = 1'b1;
            end
            SREG: w_uins.CY2 = 1'b1;
            SALU: begin
                w_uins.walu = 1'b1;
                w_uins.i    = uses_imm(inst);
                if (is_md(inst)) begin
                    w_uins.rst_md = (r_md_cnt == '0);
                    if (w_md_done) begin
                        w_uins.whilo = 1'b1;
                        w_uins.wpc   = 1'b1;
                    end else if (w_md_expire) begin
                        w_uins.wpc   = 1'b1;
                    end
                end
            end
            SLD: begin
                w_uins.wmdr = 1'b1;
                w_uins.ce   = 1'b1;
                w_uins.rw   = 1'b1;
            end
            WBK: begin
                w_uins.wreg = 1'b1;
                w_uins.wpc  = 1'b1;
            end
            SST: begin
                w_uins.ce  = 1'b1;
                w_uins.wpc = 1'b1;
                w_uins.bw  = (inst == SW);
            end
            SSALTA: w_uins.wpc = 1'b1;
            default: w_uins = '0;
        endcase
    end

    assign uins       = w_uins;
    assign md_timeout = r_md_timeout;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_control_unit.sv
// Testbench for control_unit: decode vector table plus per-cycle FSM
// sequences checked through an expected-value queue.
module tb_control_unit;
    import riscv::*;

    localparam int MDMAX = 8;

    logic            ck;
    logic            rst;
    logic [31:0]     ir;
    logic            end_mul;
    logic            end_div;
    inst_type        inst;
    microinstruction uins;
    logic            md_timeout;
    state_t          dbg_state;

    typedef struct packed {
        state_t          st;
        microinstruction u;
        logic            to;
    } obs_t;
    localparam int OW = $bits(obs_t);

    typedef struct {
        logic [31:0] ir;
        inst_type    exp;
    } dec_vec_t;

    logic [OW-1:0] exp_q[$];
    dec_vec_t      dec[$];
    int            n_checks = 0;
    int            n_errors = 0;
    string         cur_seq  = "none";
    logic [31:0]   cur_ir   = 32'h0;
    logic          e_to     = 1'b0;

    control_unit #(.MD_MAX_CYCLES(MDMAX)) dut (
        .ck         (ck),
        .rst        (rst),
        .ir         (ir),
        .end_mul    (end_mul),
        .end_div    (end_div),
        .inst       (inst),
        .uins       (uins),
        .md_timeout (md_timeout),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    initial ck = 1'b0;
    always #5 ck = ~ck;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    always @(negedge ck) begin
        if (exp_q.size() != 0) begin
            logic [OW-1:0] e;
            obs_t eo;
            obs_t ao;
            e  = exp_q.pop_front();
            eo = obs_t'(e);
            ao = '{st: dbg_state, u: uins, to: md_timeout};
            n_checks++;
            if (ao !== eo) begin
                n_errors++;
                $display("FAIL %s: state act=%0d exp=%0d uins act=%h exp=%h md_timeout act=%b exp=%b",
                         cur_seq, ao.st, eo.st, ao.u, eo.u, ao.to, eo.to);
            end
        end
    end

    // ---------------- helpers ----------------
    function automatic microinstruction mk(input logic cy1, cy2, walu, i, rst_md, whilo,
                                           input logic wpc, wmdr, ce, rw, wreg, bw);
        microinstruction u;
        u.CY1 = cy1;  u.CY2 = cy2;  u.walu = walu;  u.i = i;
        u.rst_md = rst_md;  u.whilo = whilo;  u.wpc = wpc;  u.wmdr = wmdr;
        u.ce = ce;  u.rw = rw;  u.wreg = wreg;  u.bw = bw;
        return u;
    endfunction

    microinstruction u_zero, u_fetch, u_reg, u_alu, u_alui, u_ld, u_wbk;
    microinstruction u_sw, u_sb, u_jmp, u_md1, u_mdok, u_mdto;

    // One clock cycle: drive inputs just after the edge, queue the expected
    // observation for the state entered at that edge.
    task automatic cx(input logic r, input logic em, input logic ed,
                      input state_t st, input microinstruction u);
        obs_t o;
        @(posedge ck);
        #1;
        rst     = r;
        end_mul = em;
        end_div = ed;
        ir      = cur_ir;
        o = '{st: st, u: u, to: e_to};
        exp_q.push_back(OW'(o));
        @(negedge ck);
    endtask

    task automatic c(input state_t st, input microinstruction u);
        cx(1'b0, 1'b0, 1'b0, st, u);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        u_zero  = '0;
        //            cy1 cy2 alu i  rmd hlo pc mdr ce rw wrg bw
        u_fetch = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        u_reg   = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        u_alu   = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        u_alui  = mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        u_ld    = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
        u_wbk   = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
        u_sw    = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1);
        u_sb    = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        u_jmp   = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        u_md1   = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        u_mdok  = mk(0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        u_mdto  = mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);

        dec.push_back('{32'h00000000, NOP});
        dec.push_back('{32'hFC000000, invalid_instruction});
        dec.push_back('{32'h00000040, SSLL});
        dec.push_back('{32'h00000003, SSRA});
        dec.push_back('{32'h00430006, SRLV});
        dec.push_back('{32'h03E00008, JR});
        dec.push_back('{32'h00430009, JALR});
        dec.push_back('{32'h00000010, MFHI});
        dec.push_back('{32'h00000012, MFLO});
        dec.push_back('{32'h00430019, MULTU});
        dec.push_back('{32'h0043001B, DIVU});
        dec.push_back('{32'h00430021, ADDU});
        dec.push_back('{32'h00430027, NNOR});
        dec.push_back('{32'h0043002B, SLTU});
        dec.push_back('{32'h00430001, invalid_instruction});
        dec.push_back('{32'h08000010, J});
        dec.push_back('{32'h0C000010, JAL});
        dec.push_back('{32'h10430004, BEQ});
        dec.push_back('{32'h14430004, BNE});
        dec.push_back('{32'h18400004, BLEZ});
        dec.push_back('{32'h1C400004, invalid_instruction});
        dec.push_back('{32'h04410004, BGEZ});
        dec.push_back('{32'h04400004, invalid_instruction});
        dec.push_back('{32'h20430004, ADDI});
        dec.push_back('{32'h24430004, ADDI});
        dec.push_back('{32'h28430004, SLTI});
        dec.push_back('{32'h2C430004, SLTIU});
        dec.push_back('{32'h30430004, ANDI});
        dec.push_back('{32'h34430004, ORI});
        dec.push_back('{32'h38430004, XORI});
        dec.push_back('{32'h3C030004, LUI});
        dec.push_back('{32'h8C430004, LW});
        dec.push_back('{32'h90430004, LBU});
        dec.push_back('{32'hA0430004, SB});
        dec.push_back('{32'hAC430004, SW});

        rst = 1'b1;  ir = 32'h0;  end_mul = 1'b0;  end_div = 1'b0;
        repeat (2) @(posedge ck);

        // Decode table, FSM parked in reset.
        foreach (dec[k]) begin
            ir = dec[k].ir;
            #1;
            n_checks++;
            if (inst !== dec[k].exp) begin
                n_errors++;
                $display("FAIL decode[%0d] ir=%h: inst act=%s exp=%s",
                         k, dec[k].ir, inst.name(), dec[k].exp.name());
            end
        end

        // Reset state then LW.
        cur_seq = "lw";   cur_ir = 32'h8C430004;
        cx(1'b0, 1'b0, 1'b0, SIDLE, u_zero);
        c(SFETCH, u_fetch); c(SREG, u_reg); c(SALU, u_alui); c(SLD, u_ld); c(WBK, u_wbk);

        cur_seq = "sw";   cur_ir = 32'hAC430004;
        c(SFETCH, u_fetch); c(SREG, u_reg); c(SALU, u_alui); c(SST, u_sw);

        cur_seq = "sb";   cur_ir = 32'hA0430004;
        c(SFETCH, u_fetch); c(SREG, u_reg); c(SALU, u_alui); c(SST, u_sb);

        cur_seq = "nop";  cur_ir = 32'h00000000;
        c(SFETCH, u_fetch); c(SREG, u_reg);

        cur_seq = "inval"; cur_ir = 32'hFC000000;
        c(SFETCH, u_fetch); c(SREG, u_reg);

        cur_seq = "addu"; cur_ir = 32'h00430021;
        c(SFETCH, u_fetch); c(SREG, u_reg); c(SALU, u_alu); c(WBK, u_wbk);

        cur_seq = "addi"; cur_ir = 32'h20430004;
        c(SFETCH, u_fetch); c(SREG, u_reg); c(SALU, u_alui); c(WBK, u_wbk);

        cur_seq = "beq";  cur_ir = 32'h10430004;
        c(SFETCH, u_fetch); c(SREG, u_reg); c(SALU, u_alu); c(SSALTA, u_jmp);

        // MULTU: divider pulses ignored, multiplier done on 5th SALU cycle.
        cur_seq = "multu"; cur_ir = 32'h00430019;
        c(SFETCH, u_fetch); c(SREG, u_reg);
        c(SALU, u_md1);
        cx(1'b0, 1'b0, 1'b1, SALU, u_alu);
        c(SALU, u_alu);
        cx(1'b0, 1'b0, 1'b1, SALU, u_alu);
        cx(1'b0, 1'b1, 1'b0, SALU, u_mdok);

        // DIVU without end_div: exactly MDMAX SALU cycles, then timeout.
        cur_seq = "divu_to"; cur_ir = 32'h0043001B;
        c(SFETCH, u_fetch); c(SREG, u_reg);
        cx(1'b0, 1'b1, 1'b0, SALU, u_md1);
        for (int k = 2; k < MDMAX; k++) c(SALU, u_alu);
        c(SALU, u_mdto);
        e_to = 1'b1;

        // DIVU completing normally; timeout flag stays set, count restarted.
        cur_seq = "divu_ok";
        c(SFETCH, u_fetch); c(SREG, u_reg);
        c(SALU, u_md1);
        cx(1'b0, 1'b0, 1'b1, SALU, u_mdok);

        // Reset in the middle of a MULTU wait, with end_mul in the same cycle.
        cur_seq = "rst_mid"; cur_ir = 32'h00430019;
        c(SFETCH, u_fetch); c(SREG, u_reg);
        c(SALU, u_md1);
        cx(1'b1, 1'b1, 1'b0, SALU, u_mdok);
        e_to = 1'b0;
        cx(1'b0, 1'b0, 1'b0, SIDLE, u_zero);
        c(SFETCH, u_fetch);
        c(SREG, u_reg);

        @(posedge ck);
        @(negedge ck);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL queue_drain: pending act=%0d exp=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
